// File: rtl/register_chain_loader.sv
// rtl/register_chain_loader.sv - serial configuration chain master (readback option: REGISTER_CHAIN_LOADER_READBACK_EN)
module register_chain_loader #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             chain_data,
    output logic             chain_enable,
    output logic             chain_update,
    output logic             busy,
`ifdef REGISTER_CHAIN_LOADER_READBACK_EN
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
`endif
    input  logic             chain_return
);

    localparam int CW = $clog2(WIDTH);
    // A zero-length settle phase still needs a legal (unused) counter.
    localparam int SW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [CW-1:0] SHIFT_LAST  = CW'(WIDTH - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_SETTLE,
        ST_UPDATE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    shift_cnt;
    logic [CW-1:0]    shift_cnt_next;
    logic [SW-1:0]    settle_cnt;
    logic [SW-1:0]    settle_cnt_next;
    logic [WIDTH-1:0] word_sr;
    logic             transfer;
    logic             last_shift;

    // in_ready is registered and only high in IDLE, so it doubles as the accept gate.
    assign transfer   = in_valid && in_ready;
    assign last_shift = (shift_cnt == SHIFT_LAST);

    // Next-state and counter logic; counters stop at their terminal values, never wrap.
    always_comb begin
        state_next      = state;
        shift_cnt_next  = shift_cnt;
        settle_cnt_next = settle_cnt;
        case (state)
            ST_IDLE: begin
                if (transfer) begin
                    state_next     = ST_SHIFT;
                    shift_cnt_next = '0;
                end
            end
            ST_SHIFT: begin
                if (last_shift) begin
                    state_next      = (SETTLE_CYCLES > 0) ? ST_SETTLE : ST_UPDATE;
                    settle_cnt_next = '0;
                end else begin
                    shift_cnt_next = shift_cnt + 1'b1;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_next = ST_UPDATE;
                end else begin
                    settle_cnt_next = settle_cnt + 1'b1;
                end
            end
            ST_UPDATE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            shift_cnt  <= '0;
            settle_cnt <= '0;
        end else begin
            state      <= state_next;
            shift_cnt  <= shift_cnt_next;
            settle_cnt <= settle_cnt_next;
        end
    end

    // Control outputs are decoded from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready     <= 1'b0;
            chain_enable <= 1'b0;
            chain_update <= 1'b0;
            busy         <= 1'b0;
        end else begin
            in_ready     <= (state_next == ST_IDLE);
            chain_enable <= (state_next == ST_SHIFT);
            chain_update <= (state_next == ST_UPDATE);
            busy         <= (state_next != ST_IDLE);
        end
    end

    // MSB-first serializer: the top bit goes out on the accept edge, the rest follow one per shift edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            chain_data <= 1'b0;
            word_sr    <= '0;
        end else if (transfer) begin
            chain_data <= in_data[WIDTH-1];
            word_sr    <= {in_data[WIDTH-2:0], 1'b0};
        end else if ((state == ST_SHIFT) && !last_shift) begin
            chain_data <= word_sr[WIDTH-1];
            word_sr    <= {word_sr[WIDTH-2:0], 1'b0};
        end
    end

`ifdef REGISTER_CHAIN_LOADER_READBACK_EN
    logic [WIDTH-1:0] rd_sr;
    logic [WIDTH-1:0] rd_sr_next;

    // The farthest cell emerges first, so shifting in at the LSB leaves cell k at bit k.
    assign rd_sr_next = {rd_sr[WIDTH-2:0], chain_return};

    // Collect the old chain contents during SHIFT and publish them with the update pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_sr    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (state == ST_SHIFT) begin
                rd_sr <= rd_sr_next;
            end
            if (state_next == ST_UPDATE) begin
                rd_data <= (state == ST_SHIFT) ? rd_sr_next : rd_sr;
            end
            rd_valid <= (state_next == ST_UPDATE);
        end
    end
`else
    logic unused_chain_return;
    assign unused_chain_return = chain_return;
`endif

endmodule

// File: tb/tb_register_chain_loader.sv
// tb/tb_register_chain_loader.sv - self-checking bench for register_chain_loader with a cell-chain model
module tb_register_chain_loader;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] in_data [2];
    logic         in_valid [2];
    logic         in_ready [2];
    logic         chain_data [2];
    logic         chain_enable [2];
    logic         chain_update [2];
    logic         busy [2];
    logic         chain_return [2];
`ifdef REGISTER_CHAIN_LOADER_READBACK_EN
    logic [W-1:0] rd_data [2];
    logic         rd_valid [2];
    logic [W-1:0] rd_at_upd [2];
`endif

    int n_chk  = 0;
    int n_fail = 0;
    bit started = 0;
    int cyc = 0;

    // Reference timeline: mc = cycles since the accept edge, -1 when idle.
    int           sett [2]     = '{1, 0};
    int           mc [2]       = '{-1, -1};
    bit           mrst [2]     = '{1, 1};
    logic [W-1:0] mword [2]    = '{8'h00, 8'h00};
    logic         mdata [2]    = '{1'b0, 1'b0};
    logic [W-1:0] snap [2]     = '{8'h00, 8'h00};
    logic [W-1:0] exp_rd [2]   = '{8'h00, 8'h00};
    int           nxfer [2]    = '{0, 0};
    int           xfer_cyc [2] = '{0, 0};
    // Cell chain model: cells = shift stages, par = parallel outputs.
    logic [W-1:0] cells [2]    = '{8'h00, 8'h00};
    logic [W-1:0] par [2]      = '{8'h00, 8'h00};
    logic         s_en [2]     = '{1'b0, 1'b0};
    logic         s_dat [2]    = '{1'b0, 1'b0};
    logic         prev_upd [2] = '{1'b0, 1'b0};
    int           upd_cnt [2]  = '{0, 0};
    int           upd_cyc [2]  = '{0, 0};
    logic [W-1:0] seq [2]      = '{8'h00, 8'h00};

    always #5 clk = ~clk;

    assign chain_return[0] = cells[0][W-1];
    assign chain_return[1] = cells[1][W-1];

    register_chain_loader #(.WIDTH(W), .SETTLE_CYCLES(1)) dut0 (
        .clk(clk), .reset(reset), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .chain_data(chain_data[0]), .chain_enable(chain_enable[0]),
        .chain_update(chain_update[0]), .busy(busy[0]),
`ifdef REGISTER_CHAIN_LOADER_READBACK_EN
        .rd_data(rd_data[0]), .rd_valid(rd_valid[0]),
`endif
        .chain_return(chain_return[0])
    );

    register_chain_loader #(.WIDTH(W), .SETTLE_CYCLES(0)) dut1 (
        .clk(clk), .reset(reset), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .chain_data(chain_data[1]), .chain_enable(chain_enable[1]),
        .chain_update(chain_update[1]), .busy(busy[1]),
`ifdef REGISTER_CHAIN_LOADER_READBACK_EN
        .rd_data(rd_data[1]), .rd_valid(rd_valid[1]),
`endif
        .chain_return(chain_return[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model advance on each clock edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (s_en[i]) cells[i] <= {cells[i][W-2:0], s_dat[i]};
            if (reset) begin
                mc[i]     <= -1;
                mrst[i]   <= 1'b1;
                mdata[i]  <= 1'b0;
                exp_rd[i] <= '0;
            end else begin
                mrst[i] <= 1'b0;
                if (mc[i] < 0) begin
                    if (in_valid[i] && !mrst[i]) begin
                        mc[i]       <= 0;
                        mword[i]    <= in_data[i];
                        mdata[i]    <= in_data[i][W-1];
                        snap[i]     <= cells[i];
                        nxfer[i]    <= nxfer[i] + 1;
                        xfer_cyc[i] <= cyc + 1;
                    end
                end else if (mc[i] == W + sett[i]) begin
                    mc[i] <= -1;
                end else begin
                    if (mc[i] < W - 1) mdata[i] <= mword[i][W-2-mc[i]];
                    if (mc[i] == W + sett[i] - 1) exp_rd[i] <= snap[i];
                    mc[i] <= mc[i] + 1;
                end
            end
        end
    end

    // Compare DUT outputs against the timeline every cycle; also drive the cell model.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (started) begin
                chk($sformatf("in_ready[%0d]", i), in_ready[i], (mc[i] < 0) && !mrst[i]);
                chk($sformatf("busy[%0d]", i), busy[i], mc[i] >= 0);
                chk($sformatf("chain_enable[%0d]", i), chain_enable[i], (mc[i] >= 0) && (mc[i] < W));
                chk($sformatf("chain_update[%0d]", i), chain_update[i], mc[i] == W + sett[i]);
                chk($sformatf("chain_data[%0d]", i), chain_data[i], mdata[i]);
                chk($sformatf("no_overlap[%0d]", i), chain_enable[i] && chain_update[i], 0);
`ifdef REGISTER_CHAIN_LOADER_READBACK_EN
                chk($sformatf("rd_valid[%0d]", i), rd_valid[i], mc[i] == W + sett[i]);
                chk($sformatf("rd_data[%0d]", i), rd_data[i], exp_rd[i]);
                if (chain_update[i]) rd_at_upd[i] <= rd_data[i];
`endif
            end
            s_en[i]  <= chain_enable[i];
            s_dat[i] <= chain_data[i];
            if (chain_enable[i]) seq[i] <= {seq[i][W-2:0], chain_data[i]};
            prev_upd[i] <= chain_update[i];
            if (chain_update[i] && !prev_upd[i]) begin
                par[i]     <= cells[i];
                upd_cnt[i] <= upd_cnt[i] + 1;
                upd_cyc[i] <= cyc;
            end
        end
    end

    task automatic load(input int i, input logic [W-1:0] w, input bit keep);
        int n0 = nxfer[i];
        in_data[i]  = w;
        in_valid[i] = 1'b1;
        for (int k = 0; k < 40 && nxfer[i] == n0; k++) @(negedge clk);
        chk($sformatf("xfer_timeout[%0d]", i), nxfer[i] != n0, 1);
        if (!keep) in_valid[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        int k = 0;
        while (mc[i] >= 0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("idle_timeout[%0d]", i), mc[i] < 0, 1);
        @(negedge clk);
    endtask

    initial begin
        int t1;
        int u0;
        int n0;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b0;
            in_data[i]  = '0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_in_ready", in_ready[i], 0);
            chk("rst_busy", busy[i], 0);
            chk("rst_enable", chain_enable[i], 0);
            chk("rst_update", chain_update[i], 0);
            chk("rst_data", chain_data[i], 0);
        end
        started = 1;
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", in_ready[0], 1);

        // Single load 0xA5
        load(0, 8'hA5, 0);
        wait_idle(0);
        chk("a5_latency", upd_cyc[0] - xfer_cyc[0] + 1, 10);
        chk("a5_serial", seq[0], 8'hA5);
        chk("a5_par", par[0], 8'hA5);

        // Back-to-back 0xFF then 0x3C with in_valid held
        load(0, 8'hFF, 1);
        t1 = xfer_cyc[0];
        load(0, 8'h3C, 0);
        chk("b2b_spacing", xfer_cyc[0] - t1, 11);
        wait_idle(0);
        chk("b2b_par", par[0], 8'h3C);

        // Reset during shift cycle 4 of 0x0F
        u0 = upd_cnt[0];
        load(0, 8'h0F, 0);
        for (int k = 0; k < 20 && mc[0] != 4; k++) @(negedge clk);
        chk("abort_reached", mc[0], 4);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", in_ready[0], 0);
        chk("abort_enable", chain_enable[0], 0);
        chk("abort_busy", busy[0], 0);
        chk("abort_data", chain_data[0], 0);
        reset = 1'b0;
        repeat (14) @(negedge clk);
        chk("abort_no_update", upd_cnt[0] - u0, 0);
        chk("abort_par", par[0], 8'h3C);

        // Zero settle instance, load 0x81
        load(1, 8'h81, 0);
        wait_idle(1);
        chk("s0_latency", upd_cyc[1] - xfer_cyc[1] + 1, 9);
        chk("s0_par", par[1], 8'h81);

        // in_valid toggling while busy
        n0 = nxfer[0];
        load(0, 8'h66, 0);
        for (int k = 0; k < W + 1; k++) begin
            in_valid[0] = (k % 2 == 0);
            @(negedge clk);
        end
        in_valid[0] = 1'b0;
        wait_idle(0);
        chk("toggle_xfers", nxfer[0] - n0, 1);
        chk("toggle_par", par[0], 8'h66);

`ifdef REGISTER_CHAIN_LOADER_READBACK_EN
        load(0, 8'h5A, 0);
        wait_idle(0);
        load(0, 8'hC3, 0);
        wait_idle(0);
        chk("rb_data", rd_at_upd[0], 8'h5A);
        chk("rb_par", par[0], 8'hC3);
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
